// File: rtl/eth_vlg_ram_pkg.sv
// Shared types and constants for the RAM reader stream.
// Latency: n/a. Backpressure: n/a.
package eth_vlg_ram_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;

  localparam int RD_FIFO_DEPTH = 4;
  localparam int RAM_RD_LAT    = 1;

  // Per-read markers that travel alongside the RAM read latency.
  typedef struct packed {
    logic vld;
    logic sof;
    logic eof;
  } rd_tag_t;

endpackage

// File: rtl/eth_vlg_rd_fifo.sv
// Small synchronous FIFO holding fetched words with their frame markers.
// Latency: write visible at head next cycle. Backpressure: none; caller must respect count.
module eth_vlg_rd_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr,
  input  logic [W-1:0]                 wr_dat,
  input  logic                         rd,
  output logic [W-1:0]                 rd_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (rd) rd_ptr <= rd_ptr + PW'(1);
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_dat = mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr && !rd && (count == ($clog2(DEPTH+1))'(DEPTH))));

endmodule

// File: rtl/eth_vlg_ram_rd_stream.sv
// Fetches len words from a RAM port starting at addr and emits them as a sof/eof stream.
// Latency: first val 3 cycles after request acceptance. Backpressure: rdy stalls output; reads pause when FIFO credits run out.
module eth_vlg_ram_rd_stream
  import eth_vlg_ram_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_val,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  output logic          req_rdy,
  output logic [AW-1:0] ram_a,
  output logic          ram_w,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_q,
  output logic [DW-1:0] dat,
  output logic          val,
  output logic          sof,
  output logic          eof,
  input  logic          rdy,
  output logic          done
);

  localparam int CW = $clog2(RD_FIFO_DEPTH + 1);

  rd_state_t     state;
  logic [LW-1:0] len_q;
  logic [LW-1:0] issued;
  logic [1:0]    inflight;
  logic [CW-1:0] fifo_count;
  logic [DW+1:0] fifo_head;
  rd_tag_t       tag_pipe [RAM_RD_LAT];
  logic          issue;
  logic          push;
  logic          pop;

  assign ram_w = 1'b0;
  assign ram_d = '0;

  // Credit: never issue more reads than the FIFO can hold once they land.
  assign issue = (state == READ) && (issued < len_q) &&
                 ((4'(fifo_count) + 4'(inflight)) < 4'(RD_FIFO_DEPTH));
  assign push  = tag_pipe[RAM_RD_LAT-1].vld;
  assign val   = (fifo_count != '0);
  assign pop   = val && rdy;
  assign dat   = fifo_head[DW-1:0];
  assign sof   = val && fifo_head[DW+1];
  assign eof   = val && fifo_head[DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ram_a   <= '0;
      len_q   <= '0;
      issued  <= '0;
      done    <= 1'b0;
      req_rdy <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_val) begin
            issued <= '0;
            len_q  <= req_len;
            if (req_len == '0) begin
              done <= 1'b1;
            end else begin
              ram_a   <= req_addr;
              state   <= READ;
              req_rdy <= 1'b0;
            end
          end
        end
        READ: begin
          if (issue) begin
            ram_a  <= ram_a + AW'(1);
            issued <= issued + LW'(1);
            if (issued + LW'(1) == len_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && eof) begin
            state   <= IDLE;
            done    <= 1'b1;
            req_rdy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_RD_LAT; i++) tag_pipe[i] <= '0;
      inflight <= '0;
    end else begin
      tag_pipe[0] <= '{vld: issue,
                       sof: (issued == '0),
                       eof: (issued == len_q - LW'(1))};
      for (int i = 1; i < RAM_RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      inflight <= inflight + 2'(issue) - 2'(push);
    end
  end

  eth_vlg_rd_fifo #(
    .W     (DW + 2),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr     (push),
    .wr_dat ({tag_pipe[RAM_RD_LAT-1].sof, tag_pipe[RAM_RD_LAT-1].eof, ram_q}),
    .rd     (pop),
    .rd_dat (fifo_head),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_eth_vlg_ram_rd_stream.sv
// Bench for eth_vlg_ram_rd_stream: directed timing cases plus random frames
// checked against an address-arithmetic frame model.
module tb_eth_vlg_ram_rd_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_val = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic        req_rdy;
  logic [15:0] ram_a;
  logic        ram_w;
  logic [7:0]  ram_d;
  logic [7:0]  ram_q = '0;
  logic [7:0]  dat;
  logic        val, sof, eof, done;
  logic        rdy = 1'b1;

  eth_vlg_ram_rd_stream #(.AW(16), .DW(8), .LW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_addr(req_addr),
    .req_len(req_len), .req_rdy(req_rdy), .ram_a(ram_a), .ram_w(ram_w),
    .ram_d(ram_d), .ram_q(ram_q), .dat(dat), .val(val), .sof(sof),
    .eof(eof), .rdy(rdy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [65536];
  always @(posedge clk) ram_q <= mem[ram_a];

  typedef struct packed {logic s; logic e; logic [7:0] d;} beat_t;
  beat_t expq[$];

  int checks = 0;
  int failures = 0;
  int beats_seen = 0;
  bit mon_en = 0;
  bit done_due = 0;
  bit hold_v = 0;
  logic [9:0] hold_word;
  int rdy_mode = 0;
  int pidx = 0;
  int pat[6] = '{1, 0, 0, 1, 0, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: rdy = 1'b1;
      1: begin rdy = pat[pidx][0]; pidx = (pidx + 1) % 6; end
      2: rdy = 1'($urandom_range(0, 1));
      default: rdy = 1'b0;
    endcase
  end

  // Frame model: beat i of a request is mem[(addr+i) mod 2^16]; done follows the eof handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      beat_t b;
      check("done", 32'(done), 32'(done_due));
      done_due = 0;
      if (hold_v) begin
        check("hold_val", 32'(val), 1);
        check("hold_word", 32'({sof, eof, dat}), 32'(hold_word));
      end
      hold_v = val && !rdy;
      hold_word = {sof, eof, dat};
      if (val) begin
        if (expq.size() == 0) check("spurious_val", 32'(val), 0);
        else if (rdy) begin
          b = expq.pop_front();
          check("dat", 32'(dat), 32'(b.d));
          check("sof", 32'(sof), 32'(b.s));
          check("eof", 32'(eof), 32'(b.e));
          beats_seen++;
          if (b.e) done_due = 1;
        end
      end
      if (req_val && req_rdy) begin
        for (int i = 0; i < int'(req_len); i++) begin
          logic [15:0] a;
          a = req_addr + 16'(i);
          expq.push_back('{s: (i == 0), e: (i == int'(req_len) - 1), d: mem[a]});
        end
        if (req_len == 0) done_due = 1;
      end
    end
  end

  task automatic send_req(input logic [15:0] a, input logic [15:0] l);
    int n = 0;
    while (!req_rdy && n < 1000) begin @(posedge clk); #1; n++; end
    if (!req_rdy) check("req_rdy_timeout", 32'(req_rdy), 1);
    req_addr = a; req_len = l; req_val = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(req_rdy && expq.size() == 0 && !done_due && !done) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("idle_timeout", 32'(n < 2000), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a0;
    int base;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'hA0; mem[16'h0011] = 8'hA1;
    mem[16'h0012] = 8'hA2; mem[16'h0013] = 8'hA3;
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22;
    mem[16'h0000] = 8'h33; mem[16'h0001] = 8'h44;

    #12;
    check("rst_ram_a", 32'(ram_a), 0);
    check("rst_val", 32'(val), 0);
    check("rst_sof_eof", 32'({sof, eof}), 0);
    check("rst_dat", 32'(dat), 0);
    check("rst_done", 32'(done), 0);
    check("rst_req_rdy", 32'(req_rdy), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1;
    @(posedge clk); #1;

    // Nominal frame timing.
    rdy_mode = 0;
    send_req(16'h0010, 16'd4);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("t1_val_k%0d", k), 32'(val), 32'(k >= 3 && k <= 6));
      check($sformatf("t1_done_k%0d", k), 32'(done), 32'(k == 7));
      if (k == 1) check("t1_ram_a", 32'(ram_a), 32'h10);
    end
    @(posedge clk); #1;
    wait_idle();

    // Toggled ready.
    rdy_mode = 1; pidx = 0;
    send_req(16'h0010, 16'd4);
    wait_idle();

    // Credit exhaustion with ready held low.
    rdy_mode = 3;
    send_req(16'h0100, 16'd8);
    repeat (10) @(negedge clk);
    check("credit_ram_a", 32'(ram_a), 32'h104);
    check("credit_val", 32'(val), 1);
    check("credit_dat", 32'(dat), 32'(mem[16'h0100]));
    repeat (5) @(negedge clk);
    check("credit_ram_a_hold", 32'(ram_a), 32'h104);
    @(posedge clk); #1;
    rdy_mode = 2;
    wait_idle();

    // Address wrap.
    rdy_mode = 0;
    send_req(16'hFFFE, 16'd4);
    for (int k = 1; k <= 4; k++) begin
      logic [15:0] ea;
      ea = 16'hFFFE + 16'(k - 1);
      @(negedge clk);
      check($sformatf("wrap_ram_a_k%0d", k), 32'(ram_a), 32'(ea));
    end
    @(posedge clk); #1;
    wait_idle();

    // Single-word and empty frames.
    send_req(16'h0005, 16'd1);
    wait_idle();
    a0 = ram_a;
    send_req(16'h0123, 16'd0);
    @(negedge clk);
    check("len0_val", 32'(val), 0);
    check("len0_ram_a", 32'(ram_a), 32'(a0));
    @(posedge clk); #1;
    wait_idle();

    // Reset during the third beat of a long frame.
    base = beats_seen;
    send_req(16'h0200, 16'd16);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); #2;
      if (beats_seen == base + 2) break;
    end
    check("mid_beats", 32'(beats_seen - base), 2);
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_val", 32'(val), 0);
    check("mid_rst_sof_eof", 32'({sof, eof}), 0);
    check("mid_rst_dat", 32'(dat), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_ram_a", 32'(ram_a), 0);
    check("mid_rst_req_rdy", 32'(req_rdy), 1);
    expq.delete(); done_due = 0; hold_v = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_req_rdy", 32'(req_rdy), 1);
    send_req(16'h0300, 16'd2);
    wait_idle();

    // Back-to-back: next request in the done cycle.
    send_req(16'h0010, 16'd3);
    for (int n = 0; n < 100 && !done; n++) begin @(posedge clk); #1; end
    check("b2b_done_seen", 32'(done), 1);
    send_req(16'h0040, 16'd2);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("b2b_val_k%0d", k), 32'(val), 32'(k == 3));
      if (k == 3) check("b2b_sof", 32'(sof), 1);
    end
    @(posedge clk); #1;
    wait_idle();

    // Random frames.
    for (int i = 0; i < 40; i++) begin
      rdy_mode = $urandom_range(0, 2);
      send_req(16'($urandom), 16'($urandom_range(0, 10)));
      wait_idle();
    end

    check("ram_w_tie", 32'(ram_w), 0);
    check("ram_d_tie", 32'(ram_d), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
